vote_result_tabulator: RTL and testbench
========================================

Name: vote_result_tabulator

Overview:
- Downstream of the voting-machine core. Consumes the four per-candidate 8-bit vote counters once polling closes.
- On a start request in counting mode, it snapshots the counts and scans them one candidate per cycle.
- It reports the winner, the winner's count, a tie flag, a no-votes flag and the total votes.
- It then rotates the per-candidate counts onto a display output for the LED/7-segment stage.

Parameters:
- NUM_CAND, 4, number of candidates; fixes the scan length.
- CNT_W, 8, width of each candidate vote count.
- DISP_HOLD, 10, clk cycles each candidate is shown in display rotation; must be ≥1.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = voting, 1 = counting. Tabulation is only allowed when 1.
- start  input  1  request to tabulate; level-sampled.
- cand_votes  input  NUM_CAND*CNT_W  packed counts; candidate i is at bits [i*CNT_W +: CNT_W].
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse when results become valid.
- winner_idx  output  2  index of the winning candidate, $clog2(NUM_CAND) bits.
- winner_votes  output  CNT_W  the winner's count.
- tie  output  1  at least two candidates share the maximum, and that maximum is >0.
- no_votes  output  1  all snapshot counts are zero.
- total_votes  output  CNT_W+2  sum of all counts; no overflow is possible.
- disp_idx  output  2  candidate currently shown.
- disp_votes  output  CNT_W  count of the candidate currently shown.

Behaviour:
- Reset (synchronous, active-high, clock clk): every output is 0, the state is IDLE, and the snapshot and accumulators are cleared. Reset overrides all other inputs on the same edge.
- States: IDLE, SCAN, DONE, DISPLAY.
- IDLE → SCAN: on an edge where start=1 and mode=1.
  - Capture cand_votes into the snapshot register.
  - Clear the accumulators: max=0, idx=0, tie=0, sum=0.
  - Set the scan pointer to 0.
  - start with mode=0 is ignored.
- SCAN: each edge processes candidate p = scan pointer using the snapshot only; later cand_votes changes are ignored.
  - sum += v[p].
  - If v[p] > max: max = v[p], idx = p, tie = 0.
  - Else if v[p] == max and max != 0: tie = 1.
  - Ties resolve to the lowest index.
  - After p = NUM_CAND-1, go to DONE. A scan takes exactly NUM_CAND cycles.
- DONE (one cycle):
  - Register winner_idx, winner_votes, tie, total_votes, and no_votes = (sum == 0).
  - Pulse done=1. done rises NUM_CAND+1 edges after the start edge (5 for the default).
  - Go to DISPLAY with disp_idx=0 and the hold counter at 0.
- DISPLAY:
  - disp_votes = snapshot[disp_idx], registered.
  - The hold counter counts 0..DISP_HOLD-1. At terminal count, disp_idx increments, wrapping NUM_CAND-1 → 0.
  - A start with mode=1 re-enters SCAN (re-tabulation). Result outputs hold their old values until the next DONE.
- mode=0 in SCAN or DISPLAY: return to IDLE on that edge.
  - An aborted scan produces no done, and result outputs keep their previous values.
  - disp_idx and disp_votes go to 0.
- busy=1 only in SCAN. start while busy is ignored.
- no_votes=1 forces winner_idx=0, winner_votes=0 and tie=0.
- Result outputs stay valid and stable from DONE until the next DONE or reset.

Decomposition:
- Shared package vote_pkg holds:
  - NUM_CAND and CNT_W.
  - CAND_IDX_W = $clog2(NUM_CAND).
  - TOTAL_W = CNT_W + $clog2(NUM_CAND).
  - The tab_state_t enum {IDLE, SCAN, DONE, DISPLAY}.
- One natural sub-module, result_display_rotator:
  - Contains the hold counter, the disp_idx wrap and the snapshot mux.
  - Has enable and clear inputs.

Test Plan:
- Distinct counts: votes {3,7,2,5}, mode=1, start for 1 cycle.
  - busy is high for 4 cycles; done pulses at edge 5.
  - Results: winner_idx=1, winner_votes=7, tie=0, total_votes=17, no_votes=0.
- Tie: votes {6,2,6,1}.
  - Results: winner_idx=0, winner_votes=6, tie=1, total_votes=15.
  - Then votes {1,4,9,9}: winner_idx=2, tie=1.
- Empty and saturated inputs:
  - Votes {0,0,0,0}: no_votes=1, winner_idx=0, tie=0, total_votes=0.
  - Votes {255,255,255,255}: total_votes=1020, tie=1.
- Snapshot and guards:
  - Change cand_votes mid-SCAN: results reflect the start-edge values.
  - start with mode=0: no busy, no done.
  - A second start during SCAN is ignored.
- Abort and reset:
  - Drop mode to 0 on SCAN cycle 2: state returns to IDLE, no done, prior results are unchanged.
  - Assert reset in DISPLAY: all outputs are 0 on the next edge.
- Display rotation, DISP_HOLD=10, votes {3,7,2,5}:
  - disp_idx steps 0,1,2,3,0 every 10 cycles.
  - disp_votes follows 3,7,2,5,3.

Source files
------------

// File: rtl/vote_result_tabulator_pkg.sv
// rtl/vote_result_tabulator_pkg.sv - shared sizes and state type for the vote tabulator
package vote_pkg;
  localparam int NUM_CAND   = 4;
  localparam int CNT_W      = 8;
  localparam int CAND_IDX_W = $clog2(NUM_CAND);
  localparam int TOTAL_W    = CNT_W + $clog2(NUM_CAND);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    DONE    = 2'd2,
    DISPLAY = 2'd3
  } tab_state_t;
endpackage

// File: rtl/vote_result_tabulator_if.sv
// rtl/vote_result_tabulator_if.sv - control, vote input and result bundle of the tabulator
interface vote_result_tabulator_if;
  import vote_pkg::*;

  logic                         mode;
  logic                         start;
  logic [NUM_CAND*CNT_W-1:0]    cand_votes;
  logic                         busy;
  logic                         done;
  logic [CAND_IDX_W-1:0]        winner_idx;
  logic [CNT_W-1:0]             winner_votes;
  logic                         tie;
  logic                         no_votes;
  logic [TOTAL_W-1:0]           total_votes;
  logic [CAND_IDX_W-1:0]        disp_idx;
  logic [CNT_W-1:0]             disp_votes;

  modport master (
    output mode, start, cand_votes,
    input  busy, done, winner_idx, winner_votes, tie, no_votes, total_votes,
    input  disp_idx, disp_votes
  );

  modport slave (
    input  mode, start, cand_votes,
    output busy, done, winner_idx, winner_votes, tie, no_votes, total_votes,
    output disp_idx, disp_votes
  );
endinterface

// File: rtl/vote_result_tabulator_rotator.sv
// rtl/vote_result_tabulator_rotator.sv - cycles the snapshot counts onto the display outputs
module result_display_rotator
  import vote_pkg::*;
#(
  parameter int DISP_HOLD = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      show,
  input  logic                      restart,
  input  logic [NUM_CAND*CNT_W-1:0] snap,
  output logic [CAND_IDX_W-1:0]     disp_idx,
  output logic [CNT_W-1:0]          disp_votes
);
  localparam int HOLD_W = (DISP_HOLD > 1) ? $clog2(DISP_HOLD) : 1;
  localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(DISP_HOLD - 1);
  localparam logic [CAND_IDX_W-1:0] IDX_LAST  = CAND_IDX_W'(NUM_CAND - 1);

  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [CAND_IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]      votes_q, votes_d;

  always_comb begin
    hold_d  = hold_q;
    idx_d   = idx_q;
    votes_d = votes_q;
    if (!show) begin
      hold_d  = '0;
      idx_d   = '0;
      votes_d = '0;
    end else if (restart) begin
      // first display cycle always starts on candidate 0
      hold_d  = '0;
      idx_d   = '0;
      votes_d = snap[0 +: CNT_W];
    end else begin
      if (hold_q == HOLD_LAST) begin
        hold_d = '0;
        idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        hold_d = hold_q + 1'b1;
      end
      votes_d = snap[idx_d*CNT_W +: CNT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q  <= '0;
      idx_q   <= '0;
      votes_q <= '0;
    end else begin
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      votes_q <= votes_d;
    end
  end

  assign disp_idx   = idx_q;
  assign disp_votes = votes_q;
endmodule

// File: rtl/vote_result_tabulator.sv
// rtl/vote_result_tabulator.sv - snapshots candidate counts, scans for the winner, then rotates the display
module vote_result_tabulator
  import vote_pkg::*;
#(
  parameter int DISP_HOLD = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  vote_result_tabulator_if.slave  bus
);
  localparam int VEC_W = NUM_CAND * CNT_W;
  localparam logic [CAND_IDX_W-1:0] PTR_LAST = CAND_IDX_W'(NUM_CAND - 1);

  tab_state_t            state_q, state_d;
  logic [VEC_W-1:0]      snap_q, snap_d;
  logic [CAND_IDX_W-1:0] ptr_q, ptr_d;
  logic [CAND_IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]      max_q, max_d;
  logic                  tie_acc_q, tie_acc_d;
  logic [TOTAL_W-1:0]    sum_q, sum_d;

  logic [CAND_IDX_W-1:0] win_idx_q, win_idx_d;
  logic [CNT_W-1:0]      win_votes_q, win_votes_d;
  logic                  tie_q, tie_d;
  logic                  no_votes_q, no_votes_d;
  logic [TOTAL_W-1:0]    total_q, total_d;
  logic                  done_q, done_d;

  logic                  capture;
  logic [CNT_W-1:0]      cur_votes;

  assign cur_votes = snap_q[ptr_q*CNT_W +: CNT_W];

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    max_d       = max_q;
    tie_acc_d   = tie_acc_q;
    sum_d       = sum_q;
    win_idx_d   = win_idx_q;
    win_votes_d = win_votes_q;
    tie_d       = tie_q;
    no_votes_d  = no_votes_q;
    total_d     = total_q;
    done_d      = 1'b0;
    capture     = 1'b0;

    case (state_q)
      IDLE: capture = bus.start && bus.mode;
      SCAN: begin
        if (!bus.mode) begin
          state_d = IDLE;
        end else begin
          sum_d = sum_q + TOTAL_W'(cur_votes);
          // strict greater-than keeps the lowest index on equal counts
          if (cur_votes > max_q) begin
            max_d     = cur_votes;
            idx_d     = ptr_q;
            tie_acc_d = 1'b0;
          end else if ((cur_votes == max_q) && (max_q != '0)) begin
            tie_acc_d = 1'b1;
          end
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == PTR_LAST) state_d = DONE;
        end
      end
      DONE: begin
        done_d     = 1'b1;
        total_d    = sum_q;
        no_votes_d = (sum_q == '0);
        if (sum_q == '0) begin
          win_idx_d   = '0;
          win_votes_d = '0;
          tie_d       = 1'b0;
        end else begin
          win_idx_d   = idx_q;
          win_votes_d = max_q;
          tie_d       = tie_acc_q;
        end
        state_d = DISPLAY;
      end
      DISPLAY: begin
        if (!bus.mode) state_d = IDLE;
        else           capture = bus.start;
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      state_d   = SCAN;
      snap_d    = bus.cand_votes;
      ptr_d     = '0;
      idx_d     = '0;
      max_d     = '0;
      tie_acc_d = 1'b0;
      sum_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      snap_q      <= '0;
      ptr_q       <= '0;
      idx_q       <= '0;
      max_q       <= '0;
      tie_acc_q   <= 1'b0;
      sum_q       <= '0;
      win_idx_q   <= '0;
      win_votes_q <= '0;
      tie_q       <= 1'b0;
      no_votes_q  <= 1'b0;
      total_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      max_q       <= max_d;
      tie_acc_q   <= tie_acc_d;
      sum_q       <= sum_d;
      win_idx_q   <= win_idx_d;
      win_votes_q <= win_votes_d;
      tie_q       <= tie_d;
      no_votes_q  <= no_votes_d;
      total_q     <= total_d;
      done_q      <= done_d;
    end
  end

  result_display_rotator #(
    .DISP_HOLD (DISP_HOLD)
  ) u_rotator (
    .clk        (clk),
    .reset      (reset),
    .show       (state_d == DISPLAY),
    .restart    (state_q != DISPLAY),
    .snap       (snap_q),
    .disp_idx   (bus.disp_idx),
    .disp_votes (bus.disp_votes)
  );

  assign bus.busy         = (state_q == SCAN);
  assign bus.done         = done_q;
  assign bus.winner_idx   = win_idx_q;
  assign bus.winner_votes = win_votes_q;
  assign bus.tie          = tie_q;
  assign bus.no_votes     = no_votes_q;
  assign bus.total_votes  = total_q;
endmodule

// File: tb/tb_vote_result_tabulator.sv
// tb/tb_vote_result_tabulator.sv - scoreboard bench for the vote tabulator
module tb_vote_result_tabulator;
  logic clk;
  logic reset;

  vote_result_tabulator_if vif ();

  vote_result_tabulator #(
    .DISP_HOLD (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int votes;
    int tie;
    int total;
    int nov;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   n_checks;
  int   n_pass;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [31:0] pack(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  function automatic exp_t model(input logic [31:0] pv);
    exp_t e;
    int   v[4];
    int   mx;
    int   cnt;
    mx = 0;
    cnt = 0;
    e.total = 0;
    for (int i = 0; i < 4; i++) begin
      v[i] = int'(pv[i*8 +: 8]);
      e.total += v[i];
      if (v[i] > mx) mx = v[i];
    end
    e.idx = 0;
    for (int i = 3; i >= 0; i--) if (v[i] == mx) e.idx = i;
    for (int i = 0; i < 4; i++) if (v[i] == mx) cnt++;
    e.nov   = (e.total == 0) ? 1 : 0;
    e.votes = mx;
    e.tie   = (mx > 0 && cnt > 1) ? 1 : 0;
    if (e.nov == 1) e.idx = 0;
    return e;
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_results(input string tag, input exp_t e);
    check({tag, "_winner_idx"}, int'(vif.winner_idx), e.idx);
    check({tag, "_winner_votes"}, int'(vif.winner_votes), e.votes);
    check({tag, "_tie"}, int'(vif.tie), e.tie);
    check({tag, "_total"}, int'(vif.total_votes), e.total);
    check({tag, "_no_votes"}, int'(vif.no_votes), e.nov);
  endtask

  task automatic run_tab(input string tag, input logic [31:0] pv,
                         input bit do_alt, input logic [31:0] alt, input bit restart);
    int   k;
    int   nb;
    bit   got;
    exp_t e;
    vif.cand_votes = pv;
    vif.mode       = 1'b1;
    vif.start      = 1'b1;
    sb.push_back(model(pv));
    tick(1);
    vif.start = 1'b0;
    k   = 0;
    nb  = 0;
    got = 1'b0;
    while (k < 20 && !got) begin
      if (vif.done) begin
        got = 1'b1;
      end else begin
        if (vif.busy) nb++;
        if (k == 0 && do_alt) vif.cand_votes = alt;
        if (k == 0 && restart) vif.start = 1'b1;
        if (k == 1) vif.start = 1'b0;
        tick(1);
        k++;
      end
    end
    check({tag, "_busy_cycles"}, nb, 4);
    check({tag, "_done_latency"}, got ? k : -1, 5);
    e = sb.pop_front();
    if (got) begin
      check_results(tag, e);
      last = e;
      tick(1);
      check({tag, "_done_pulse"}, int'(vif.done), 0);
    end
  endtask

  initial begin
    int act;
    n_checks       = 0;
    n_pass         = 0;
    reset          = 1'b1;
    vif.mode       = 1'b0;
    vif.start      = 1'b0;
    vif.cand_votes = '0;
    tick(3);
    check("rst_busy", int'(vif.busy), 0);
    check("rst_done", int'(vif.done), 0);
    check("rst_results", int'({vif.winner_idx, vif.winner_votes, vif.tie, vif.no_votes}), 0);
    check("rst_total", int'(vif.total_votes), 0);
    check("rst_disp", int'({vif.disp_idx, vif.disp_votes}), 0);
    reset = 1'b0;
    tick(2);

    run_tab("distinct", pack(3, 7, 2, 5), 1'b0, '0, 1'b0);
    check("disp0_idx", int'(vif.disp_idx), 0);
    check("disp0_votes", int'(vif.disp_votes), 3);
    tick(8);
    check("disp0_hold_idx", int'(vif.disp_idx), 0);
    tick(1);
    check("disp1_idx", int'(vif.disp_idx), 1);
    check("disp1_votes", int'(vif.disp_votes), 7);
    tick(10);
    check("disp2_idx", int'(vif.disp_idx), 2);
    check("disp2_votes", int'(vif.disp_votes), 2);
    tick(10);
    check("disp3_idx", int'(vif.disp_idx), 3);
    check("disp3_votes", int'(vif.disp_votes), 5);
    tick(10);
    check("disp_wrap_idx", int'(vif.disp_idx), 0);
    check("disp_wrap_votes", int'(vif.disp_votes), 3);

    run_tab("tie_low", pack(6, 2, 6, 1), 1'b0, '0, 1'b0);
    run_tab("tie_high", pack(1, 4, 9, 9), 1'b0, '0, 1'b0);
    run_tab("empty", pack(0, 0, 0, 0), 1'b0, '0, 1'b0);
    run_tab("full", pack(255, 255, 255, 255), 1'b0, '0, 1'b0);
    run_tab("snapshot", pack(3, 7, 2, 5), 1'b1, pack(9, 9, 9, 9), 1'b1);

    vif.mode = 1'b0;
    tick(1);
    check("idle_disp", int'({vif.disp_idx, vif.disp_votes}), 0);
    vif.start = 1'b1;
    act = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (vif.busy || vif.done) act++;
    end
    vif.start = 1'b0;
    check("mode0_activity", act, 0);
    check_results("mode0_hold", last);

    vif.cand_votes = pack(1, 1, 1, 1);
    vif.mode       = 1'b1;
    vif.start      = 1'b1;
    tick(1);
    vif.start = 1'b0;
    tick(1);
    vif.mode = 1'b0;
    act = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (vif.done || vif.busy) act++;
    end
    check("abort_activity", act, 0);
    check_results("abort_hold", last);

    run_tab("pre_reset", pack(3, 7, 2, 5), 1'b0, '0, 1'b0);
    tick(3);
    reset = 1'b1;
    tick(1);
    check("dreset_busy_done", int'({vif.busy, vif.done}), 0);
    check("dreset_results", int'({vif.winner_idx, vif.winner_votes, vif.tie, vif.no_votes}), 0);
    check("dreset_total", int'(vif.total_votes), 0);
    check("dreset_disp", int'({vif.disp_idx, vif.disp_votes}), 0);
    reset = 1'b0;
    tick(2);

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
